// File: rtl/alu_stage.sv
// alu_stage: arithmetic/logic execute stage between the operand decoder and
// the tx result stage.
//
// ADD/SUB/CLR/AND/OR/XOR finish on the accept edge. MUL/MAC run an iterative
// shift-add multiply for MUL_ITERS cycles. An 18-bit MAC accumulator is kept
// here. Each accepted op produces exactly one result transfer to tx.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  op handshake from the decoder
//   opcode, op_a, op_b   op and operands, sampled on accept
//   res_data, res_carry  18-bit result and carry/borrow/overflow to tx
//   res_valid/res_ready  result handshake to tx
//   busy                 high while multiplying or holding a result
module alu_stage #(
    parameter int MUL_ITERS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  opcode,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    output logic [17:0] res_data,
    output logic        res_carry,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_MAC = 3'b011;
    localparam logic [2:0] OP_CLR = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    localparam logic [3:0] LAST_ITER = 4'(MUL_ITERS - 1);

    typedef enum logic [1:0] {IDLE, MULT, HOLD} state_t;

    state_t      state;
    logic        mac_q;     // current multiply is a MAC
    logic [15:0] mcand;     // multiplicand, shifted left each iteration
    logic [7:0]  mplier;    // multiplier, shifted right each iteration
    logic [15:0] prod;      // partial product
    logic [3:0]  cnt;       // iterations completed
    logic [17:0] acc;

    logic        accept;
    logic [8:0]  sum9;
    logic [8:0]  diff9;
    logic [17:0] quick_data;
    logic        quick_carry;
    logic [15:0] prod_nxt;
    logic [18:0] mac_sum;

    // tx can take the held result and a new op can enter on the same edge,
    // so in_ready looks straight through to res_ready while holding.
    assign in_ready  = (state == IDLE) | ((state == HOLD) & res_ready);
    assign accept    = in_valid & in_ready;
    assign res_valid = (state == HOLD);
    assign busy      = (state == MULT) | (state == HOLD);

    // Single-cycle results, computed straight from the live inputs so they
    // can be registered on the accept edge.
    always_comb begin
        quick_data  = '0;
        quick_carry = 1'b0;
        // Both are 9 bits wide: bit 8 is the carry of the add and the
        // borrow (a < b) of the subtract.
        sum9        = {1'b0, op_a} + {1'b0, op_b};
        diff9       = {1'b0, op_a} - {1'b0, op_b};
        case (opcode)
            OP_ADD: begin
                quick_data  = {10'b0, sum9[7:0]};
                quick_carry = sum9[8];
            end
            OP_SUB: begin
                quick_data  = {10'b0, diff9[7:0]};
                quick_carry = diff9[8];
            end
            OP_AND:  quick_data = {10'b0, op_a & op_b};
            OP_OR:   quick_data = {10'b0, op_a | op_b};
            OP_XOR:  quick_data = {10'b0, op_a ^ op_b};
            default: quick_data = '0;   // CLR; MUL/MAC never use this path
        endcase
    end

    // One shift-add iteration, plus the accumulate for the final edge.
    always_comb begin
        prod_nxt = prod + (mplier[0] ? mcand : 16'd0);
        mac_sum  = {1'b0, acc} + {3'b0, prod_nxt};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mac_q     <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            cnt       <= '0;
            acc       <= '0;
            res_data  <= '0;
            res_carry <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        if (opcode == OP_MUL || opcode == OP_MAC) begin
                            mac_q  <= (opcode == OP_MAC);
                            mcand  <= {8'b0, op_a};
                            mplier <= op_b;
                            prod   <= '0;
                            cnt    <= '0;
                            state  <= MULT;
                        end else begin
                            res_data  <= quick_data;
                            res_carry <= quick_carry;
                            if (opcode == OP_CLR)
                                acc <= '0;
                            state <= HOLD;
                        end
                    end else if (state == HOLD && res_ready) begin
                        state <= IDLE;
                    end
                end
                MULT: begin
                    prod   <= prod_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt == LAST_ITER) begin
                        cnt <= '0;
                        if (mac_q) begin
                            res_data  <= mac_sum[17:0];
                            res_carry <= mac_sum[18];
                            acc       <= mac_sum[17:0];   // wraps mod 2^18
                        end else begin
                            res_data  <= {2'b0, prod_nxt};
                            res_carry <= 1'b0;
                        end
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_stage.md
# alu_stage

Arithmetic/logic execute stage between the operand decoder and the `tx` result stage. It accepts one operation per valid/ready handshake and executes it. Logic and add/sub ops take a single cycle; multiply ops use an 8-iteration shift-add sequence. It holds an 18-bit MAC accumulator and presents an 18-bit result plus carry to `tx` over a valid/ready handshake.

## Interface
Parameters:
- `MUL_ITERS`, default 8. Shift-add iterations per multiply; fixed at 8 for 8-bit operands.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operation presented by decoder
- `in_ready`  out  1  stage can accept an operation this cycle
- `opcode`  in  3  operation select, sampled on accept
- `op_a`  in  8  operand A, sampled on accept
- `op_b`  in  8  operand B, sampled on accept
- `res_data`  out  18  result to `tx`
- `res_carry`  out  1  carry/borrow/overflow to `tx`
- `res_valid`  out  1  result valid to `tx`
- `res_ready`  in  1  `tx` accepts result
- `busy`  out  1  high in MULT or HOLD

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 MUL, 011 MAC, 100 CLR, 101 AND, 110 OR, 111 XOR. All codes are legal.
- ADD: sum = a+b (9 bits). `res_data` = {10'b0, sum[7:0]}. `res_carry` = sum[8].
- SUB: `res_data` = {10'b0, (a-b) mod 256}. `res_carry` = 1 when a<b (borrow).
- MUL: product = a*b (16 bits). `res_data` = {2'b0, product}. `res_carry` = 0. The accumulator is unchanged.
- MAC: s = acc + product (19 bits). `res_data` = s[17:0]. `res_carry` = s[18]. acc <= s[17:0], wrapping modulo 2^18.
- CLR: acc <= 0. `res_data` = 0. `res_carry` = 0.
- AND/OR/XOR: `res_data` = {10'b0, a op b}. `res_carry` = 0.
- Every accepted op, CLR included, produces exactly one result transfer.
- FSM states:
  - IDLE: `in_ready`=1, `res_valid`=0. On accept:
    - MUL/MAC → MULT.
    - Any other opcode → result registered on the accept edge, go to HOLD.
  - MULT: `in_ready`=0. Each edge performs one iteration: if multiplier LSB is 1, add the multiplicand into the partial product; shift the multiplicand left and the multiplier right; the 4-bit iteration counter increments. On the edge where the counter completes iteration 8, `res_data`/`res_carry` are written (MAC also updates acc) and the FSM goes to HOLD.
  - HOLD: `res_valid`=1; `res_data`/`res_carry` stable.
    - res_ready=1 and in_valid=0 → IDLE.
    - res_ready=1 and in_valid=1 → new op is accepted on the same edge; next state is MULT or HOLD, per opcode.
    - res_ready=0 → stay in HOLD.
- `in_ready` = (state==IDLE) | (state==HOLD & res_ready). This is a combinational path from `res_ready`.
- Operands and opcode are captured into internal registers on accept. Input changes after accept have no effect.

## Timing
- Reset values: state IDLE, `in_ready`=1, `res_valid`=0, `res_data`=0, `res_carry`=0, `busy`=0, acc=0, iteration counter=0.
- Single-cycle ops: accept at edge E0 → `res_valid` high after E0 (latency 1).
- MUL/MAC: accept at E0 → iterations at E1..E8 → `res_valid` high after E8 (latency 8 cycles in MULT, then HOLD). `in_ready`=0 from after E0 until HOLD.
- Throughput:
  - Single-cycle ops: one op per cycle when `res_ready` is held high.
  - MUL/MAC: one op per 9 cycles.
- Backpressure: HOLD persists indefinitely; `res_data`/`res_carry` do not change while `res_valid`=1 and `res_ready`=0.
- Boundary cases:
  - MAC wrap: acc sets `res_carry`=1 and keeps the low 18 bits.
  - CLR followed directly by MAC: the MAC uses acc=0.
- Reset asserted mid-MULT or mid-HOLD: all state returns to reset values immediately. The partial product and pending result are discarded, and acc is cleared.
- in_valid while in MULT: ignored, since `in_ready`=0. The decoder must hold the op until `in_ready`.

## Test plan
- Reset, then ADD a=0xFF b=0x01 with res_ready=1 → after 1 cycle, res_valid=1, res_data=0x00000, res_carry=1; `in_ready` stays 1.
- SUB a=0x05 b=0x07 → res_data=0x000FE, res_carry=1. XOR a=0xA5 b=0x0F → res_data=0x000AA, res_carry=0.
- MUL a=0xFF b=0xFF → `in_ready`=0 for 8 cycles, then res_valid=1, res_data=0x0FE01, res_carry=0; acc unchanged.
- CLR; MAC a=0xFF b=0xFF four times → results 0x0FE01, 0x1FC02, 0x2FA03, 0x3F804 with carry 0; a fifth MAC → res_data=0x0F605, res_carry=1.
- Backpressure: ADD with res_ready=0 for 5 cycles and in_valid held high with a second op → res_data stable, `in_ready` follows res_ready; on the release cycle, the first result transfers and the second op is accepted on the same edge.
- rst_n pulsed low at iteration 4 of a MUL → res_valid=0 and `in_ready`=1 immediately; a subsequent MAC a=2 b=3 → res_data=0x00006, confirming acc was cleared.
